sc_config_master: RTL
=====================

// Module: sc_config_master
// PURPOSE
//  Avalon-MM initiator driving the scan-converter config/status register slave (8 config regs, 2 status regs).
//  Turns per-register update requests from the control side into byte-complete 32-bit writes.
//  Also polls the two front-end status registers and flags changes.
//  Sits between the CPU-less control logic and the config slave's avalon_s_* port.
// PARAMETERS
//  NUM_CFG_REGS   8     number of config registers written (addresses CFG_BASE_ADDR..+NUM_CFG_REGS-1)
//  CFG_BASE_ADDR  2     Avalon word address of first config register
//  POLL_INTERVAL  1024  cycles between status poll rounds (>=4)
// PORTS
//  clk_i               in   1                   single clock
//  rst_n_i             in   1                   synchronous, active-low reset
//  cfg_data_i          in   32*NUM_CFG_REGS     config words, reg k at [32k+31:32k]
//  cfg_update_i        in   NUM_CFG_REGS        1-cycle pulse per reg: mark reg k pending
//  busy_o              out  1                   high while any write pending or transaction open
//  fe_status_o         out  32                  last polled status word (address 0)
//  fe_status2_o        out  32                  last polled status word (address 1)
//  status_changed_o    out  1                   1-cycle pulse when a poll round changed either status word
//  avm_address_o       out  4                   word address
//  avm_writedata_o     out  32                  write data
//  avm_byteenable_o    out  4                   always 4'hF when write/read asserted, else 0
//  avm_write_o         out  1                   write request
//  avm_read_o          out  1                   read request
//  avm_chipselect_o    out  1                   = avm_write_o | avm_read_o
//  avm_readdata_i      in   32                  read data, valid in the accepting cycle (zero read latency)
//  avm_waitrequest_n_i in   1                   transfer accepted on a cycle where it is high
// BEHAVIOUR
//  Reset: all avm_* outputs 0, pending mask 0, fe_status*_o 0, status_changed_o 0, busy_o 0, FSM IDLE, poll timer 0.
//  Pending mask: bit k set on cfg_update_i[k]; cleared when write to reg k is accepted.
//  Simultaneous set and accept of same bit -> bit stays set; reg rewritten with fresh data.
//  FSM states IDLE, WR, RD0, RD1.
//  IDLE: pending!=0 -> WR on lowest set index k.
//   Latch address CFG_BASE_ADDR+k and cfg_data_i[k] into output regs; request issued next cycle.
//  IDLE: else poll_due -> RD0.
//  WR: hold address/data/write stable while waitrequest_n low.
//   On accept: clear bit k; next state IDLE (writes re-arbitrated each time).
//  RD0: read addr 0, on accept capture readdata into shadow0 -> RD1.
//  RD1: read addr 1, on accept capture shadow1.
//   Then update fe_status*_o from the shadows.
//   Pulse status_changed_o for 1 cycle if either differs from its previous output value.
//   Clear poll_due, -> IDLE.
//  Writes take priority over polls only at IDLE; an open poll round (RD0/RD1) completes first.
//  Poll timer: counts every cycle, wraps at POLL_INTERVAL-1, sets poll_due at wrap.
//   poll_due is sticky until a round completes; extra wraps while due are dropped.
//  Min latency update pulse -> write accepted: 2 cycles with waitrequest_n=1 (latch, issue).
//  First poll round after reset never pulses status_changed_o unless a status value != 0.
//  Read and write never asserted in the same cycle.
//  busy_o = (pending!=0) | (state==WR).
//  Reset mid-transaction: request dropped at that edge; pending updates lost.
// CONFIGURATION
//  SC_CFG_POLL_EN defined: status polling, RD0/RD1, fe_status*_o, status_changed_o as above.
//  SC_CFG_POLL_EN undefined: no timer/RD states; avm_read_o, fe_status*_o, status_changed_o tied 0.
// STRUCTURE
//  sc_config_pkg: register-number localparams (FE_STATUS=0, FE_STATUS2=1, HV_OUT_CONFIG=2 .. SL_CONFIG2=9),
//   shared with the slave; typedef enum logic [1:0] sc_cfg_state_t {IDLE,WR,RD0,RD1}.
//  Sub-module sc_cfg_prio_enc: combinational lowest-set-bit encoder over the pending mask (index + valid).
// TESTING
//  Basic write: cfg_update_i=8'h01, cfg_data_i[0]=32'hDEADBEEF, waitrequest_n=1
//   -> single write addr 2, data DEADBEEF, BE F, 2 cycles after pulse.
//  Ordering: cfg_update_i=8'h81 -> write addr 2 accepted, then addr 9 accepted; busy_o drops after second.
//  Backpressure: waitrequest_n low 5 cycles during write
//   -> address/data/write held stable all 5 cycles; exactly one accepted transfer.
//  Re-update collision: cfg_update_i[3] pulses in accept cycle of reg 3 with new data 32'h12345678
//   -> second write to addr 5 with 12345678.
//  Poll (POLL_INTERVAL=16): status 0x1->0x2 on address 1
//   -> reads addr 0 then 1 each round; fe_status2_o=0x2, one status_changed_o pulse; no pulse next round.
//  Macro off: run all above -> avm_read_o never asserted, status outputs stay 0, write scenarios unchanged.

Source files
------------

// File: rtl/sc_config_pkg.sv
// Register map shared with the scan-converter config slave, plus the master FSM state type.
package sc_config_pkg;

  localparam logic [3:0] FE_STATUS      = 4'd0;
  localparam logic [3:0] FE_STATUS2     = 4'd1;
  localparam logic [3:0] HV_OUT_CONFIG  = 4'd2;
  localparam logic [3:0] HV_OUT_CONFIG2 = 4'd3;
  localparam logic [3:0] HV_OUT_CONFIG3 = 4'd4;
  localparam logic [3:0] XY_OUT_CONFIG  = 4'd5;
  localparam logic [3:0] XY_OUT_CONFIG2 = 4'd6;
  localparam logic [3:0] XY_OUT_CONFIG3 = 4'd7;
  localparam logic [3:0] SL_CONFIG      = 4'd8;
  localparam logic [3:0] SL_CONFIG2     = 4'd9;

  localparam int unsigned SC_DATA_W = 32;
  localparam int unsigned SC_ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD0  = 2'd2,
    RD1  = 2'd3
  } sc_cfg_state_t;

endpackage

// File: rtl/sc_cfg_prio_enc.sv
// Lowest-set-bit encoder over the pending-write mask.
// Latency: combinational.
// Backpressure: none, pure function of the mask.
module sc_cfg_prio_enc #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [WIDTH-1:0] mask,
  output logic [IDX_W-1:0] idx,
  output logic             idx_vld
);

  // Scan from the top so the lowest set bit is the last one to win.
  always_comb begin
    idx     = '0;
    idx_vld = 1'b0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx     = IDX_W'(i);
        idx_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sc_config_master.sv
// Avalon-MM initiator: pending config-register writes plus status polling (SC_CFG_POLL_EN).
// Latency: update pulse -> write accepted in 2 cycles when the slave does not stall.
// Backpressure: request held stable while avm_waitrequest_n_i is low.
module sc_config_master
  import sc_config_pkg::*;
#(
  parameter int unsigned NUM_CFG_REGS  = 8,
  parameter int unsigned CFG_BASE_ADDR = 2,
  parameter int unsigned POLL_INTERVAL = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [32*NUM_CFG_REGS-1:0] cfg_data_i,
  input  logic [NUM_CFG_REGS-1:0]    cfg_update_i,
  output logic                       busy_o,
  output logic [31:0]                fe_status_o,
  output logic [31:0]                fe_status2_o,
  output logic                       status_changed_o,
  output logic [3:0]                 avm_address_o,
  output logic [31:0]                avm_writedata_o,
  output logic [3:0]                 avm_byteenable_o,
  output logic                       avm_write_o,
  output logic                       avm_read_o,
  output logic                       avm_chipselect_o,
  input  logic [31:0]                avm_readdata_i,
  input  logic                       avm_waitrequest_n_i
);

  localparam int unsigned IDX_W = (NUM_CFG_REGS > 1) ? $clog2(NUM_CFG_REGS) : 1;

  sc_cfg_state_t             state_q, state_d;
  logic [NUM_CFG_REGS-1:0]   pending_q;
  logic [NUM_CFG_REGS-1:0]   clr_mask;
  logic [SC_ADDR_W-1:0]      addr_q, addr_d;
  logic [SC_DATA_W-1:0]      wdata_q, wdata_d;
  logic                      write_q, write_d;
  logic                      read_q, read_d;
  logic [IDX_W-1:0]          wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]          lo_idx;
  logic                      lo_vld;

  sc_cfg_prio_enc #(
    .WIDTH (NUM_CFG_REGS),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .mask    (pending_q),
    .idx     (lo_idx),
    .idx_vld (lo_vld)
  );

`ifdef SC_CFG_POLL_EN
  localparam int unsigned TMR_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;

  logic [TMR_W-1:0]     tmr_q;
  logic                 tmr_wrap;
  logic                 poll_due_q;
  logic                 cap0;
  logic                 round_done;
  logic [SC_DATA_W-1:0] shadow0_q;
  logic [SC_DATA_W-1:0] status_q, status2_q;
  logic                 changed_q;
`endif

  // Next-state and next request registers; writes win only when IDLE.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    read_d   = read_q;
    wr_idx_d = wr_idx_q;
    clr_mask = '0;
`ifdef SC_CFG_POLL_EN
    cap0       = 1'b0;
    round_done = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (lo_vld) begin
          state_d  = WR;
          addr_d   = SC_ADDR_W'(CFG_BASE_ADDR + 32'(lo_idx));
          wdata_d  = cfg_data_i[32*lo_idx +: 32];
          write_d  = 1'b1;
          wr_idx_d = lo_idx;
        end
`ifdef SC_CFG_POLL_EN
        else if (poll_due_q) begin
          state_d = RD0;
          addr_d  = FE_STATUS;
          read_d  = 1'b1;
        end
`endif
      end
      WR: begin
        if (avm_waitrequest_n_i) begin
          clr_mask[wr_idx_q] = 1'b1;
          write_d            = 1'b0;
          state_d            = IDLE;
        end
      end
`ifdef SC_CFG_POLL_EN
      RD0: begin
        if (avm_waitrequest_n_i) begin
          cap0    = 1'b1;
          addr_d  = FE_STATUS2;
          state_d = RD1;
        end
      end
      RD1: begin
        if (avm_waitrequest_n_i) begin
          round_done = 1'b1;
          read_d     = 1'b0;
          state_d    = IDLE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        write_d = 1'b0;
        read_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A fresh update landing on the accept cycle keeps its bit set, so the register is rewritten.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pending_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      read_q    <= 1'b0;
      wr_idx_q  <= '0;
    end else begin
      pending_q <= (pending_q & ~clr_mask) | cfg_update_i;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      read_q    <= read_d;
      wr_idx_q  <= wr_idx_d;
    end
  end

`ifdef SC_CFG_POLL_EN
  assign tmr_wrap = (tmr_q == TMR_W'(POLL_INTERVAL - 1));

  // poll_due is sticky; a wrap while a round is already owed is simply dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      tmr_q      <= '0;
      poll_due_q <= 1'b0;
      shadow0_q  <= '0;
      status_q   <= '0;
      status2_q  <= '0;
      changed_q  <= 1'b0;
    end else begin
      tmr_q      <= tmr_wrap ? '0 : tmr_q + TMR_W'(1);
      poll_due_q <= round_done ? 1'b0 : (poll_due_q | tmr_wrap);
      changed_q  <= 1'b0;
      if (cap0) begin
        shadow0_q <= avm_readdata_i;
      end
      if (round_done) begin
        status_q  <= shadow0_q;
        status2_q <= avm_readdata_i;
        changed_q <= (shadow0_q != status_q) || (avm_readdata_i != status2_q);
      end
    end
  end

  assign fe_status_o      = status_q;
  assign fe_status2_o     = status2_q;
  assign status_changed_o = changed_q;
  assign avm_read_o       = read_q;
`else
  logic unused_poll;
  assign unused_poll      = (^avm_readdata_i) ^ (POLL_INTERVAL == 0) ^ read_q;
  assign fe_status_o      = '0;
  assign fe_status2_o     = '0;
  assign status_changed_o = 1'b0;
  assign avm_read_o       = 1'b0;
`endif

  assign avm_address_o    = addr_q;
  assign avm_writedata_o  = wdata_q;
  assign avm_write_o      = write_q;
  assign avm_chipselect_o = write_q | avm_read_o;
  assign avm_byteenable_o = (write_q | avm_read_o) ? 4'hF : 4'h0;
  assign busy_o           = (|pending_q) | (state_q == WR);

endmodule
